alu_seq_ctrl: RTL and testbench

Multicycle issue/writeback controller that drives the 16-bit ALU from the initiator side. It accepts one instruction per handshake, reads operands from the register file, and presents in1/in2/ALU_op to the ALU. It then samples out/carry/zero/compare, updates the architectural C and Z flags, and performs conditional register writeback. It covers ADD, ADC, ADZ, ADI, NDU, NDC, NDZ between the core's fetch/decode logic, the register file and the ALU.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_flag_reg.sv | 28 ++
 rtl/alu_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback controller.
// Holds the opcode and CZ field encodings, the FSM state type and the
// 6-bit immediate sign-extension helper used by ADI.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADI  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_BEQ  = 4'b1100;

  localparam logic [1:0] CZ_NONE = 2'b00;
  localparam logic [1:0] CZ_C    = 2'b10;
  localparam logic [1:0] CZ_Z    = 2'b01;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StEx,
    StWb
  } state_e;

  function automatic logic [15:0] sext6(input logic [5:0] imm);
    return {{10{imm[5]}}, imm};
  endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// Architectural carry/zero flag storage.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset (flags clear to 0)
//   we_c, we_z     - independent write enables for C and Z
//   c_new, z_new   - values written when the matching enable is high
//   flag_c, flag_z - current flag values
module alu_flag_reg (
  input  logic clk,
  input  logic rst_n,
  input  logic we_c,
  input  logic we_z,
  input  logic c_new,
  input  logic z_new,
  output logic flag_c,
  output logic flag_z
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      if (we_c) flag_c <= c_new;
      if (we_z) flag_z <= z_new;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multicycle issue/writeback controller driving a 16-bit ALU.
// Accepts one instruction per handshake in IDLE, reads RA/RB from the
// register file (RD), runs the ALU (EX) and writes back / updates flags (WB).
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   instr_valid/instr_ready/instr - instruction handshake (ready only in IDLE)
//   rf_a1, rf_a2, rf_d1, rf_d2    - register file read ports (RA, RB)
//   alu_in1, alu_in2, alu_op      - ALU operands (registered) and op (0 add, 1 nand)
//   alu_out, alu_carry, alu_zero, alu_cmp - ALU results
//   rf_we, rf_a3, rf_d3           - one-cycle writeback strobe, address, data
//   flag_c, flag_z                - architectural flags
//   done, skipped, illegal        - completion pulse and its qualifiers
//   br_taken, br_off              - BEQ outcome, present only with ALU_BEQ_EN
// Optional feature macro: ALU_BEQ_EN enables opcode 1100 (BEQ).
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic [RW-1:0] rf_a1,
  output logic [RW-1:0] rf_a2,
  input  logic [DW-1:0] rf_d1,
  input  logic [DW-1:0] rf_d2,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic          alu_op,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_carry,
  input  logic          alu_zero,
  input  logic          alu_cmp,
  output logic          rf_we,
  output logic [RW-1:0] rf_a3,
  output logic [DW-1:0] rf_d3,
  output logic          flag_c,
  output logic          flag_z,
  output logic          done,
  output logic          skipped,
  output logic          illegal
`ifdef ALU_BEQ_EN
  ,
  output logic          br_taken,
  output logic [5:0]    br_off
`endif
);

  state_e state_q, state_d;
  logic [15:0]   instr_q;
  logic [DW-1:0] op1_q, op2_q, res_q;
  logic          carry_q, zero_q;
  // skip_q: no writeback and no flag change (condition false or illegal)
  logic          skip_q, ill_q;

  logic [3:0]    opcode;
  logic [RW-1:0] ra, rb, rc;
  logic [1:0]    cz;
  logic [5:0]    imm6;
  logic          is_add, is_adi, is_nand, is_beq, is_rtype;
  logic          legal, cond_ok, exec;
  logic          we_c, we_z;

  assign opcode = instr_q[15:12];
  assign ra     = instr_q[11:9];
  assign rb     = instr_q[8:6];
  assign rc     = instr_q[5:3];
  assign cz     = instr_q[1:0];
  assign imm6   = instr_q[5:0];

  assign is_add   = (opcode == OP_ADD);
  assign is_adi   = (opcode == OP_ADI);
  assign is_nand  = (opcode == OP_NAND);
  assign is_rtype = is_add | is_nand;

`ifdef ALU_BEQ_EN
  logic cmp_q;
  assign is_beq = (opcode == OP_BEQ);
`else
  logic unused_cmp;
  assign is_beq     = 1'b0;
  assign unused_cmp = alu_cmp;
`endif

  // CZ only qualifies R-type; ADI and BEQ reuse those bits as immediate.
  always_comb begin
    cond_ok = 1'b1;
    if (cz == CZ_C)      cond_ok = flag_c;
    else if (cz == CZ_Z) cond_ok = flag_z;
  end

  assign legal = is_adi | is_beq | (is_rtype & (cz != 2'b11));
  assign exec  = legal & (~is_rtype | cond_ok);

  assign rf_a1   = ra;
  assign rf_a2   = rb;
  assign alu_in1 = op1_q;
  assign alu_in2 = op2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      instr_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      skip_q  <= 1'b0;
      ill_q   <= 1'b0;
`ifdef ALU_BEQ_EN
      cmp_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && instr_valid) instr_q <= instr;
      if (state_q == StRd) begin
        op1_q  <= rf_d1;
        op2_q  <= is_adi ? sext6(imm6) : rf_d2;
        skip_q <= ~exec;
        ill_q  <= ~legal;
      end
      if (state_q == StEx) begin
        res_q   <= alu_out;
        carry_q <= alu_carry;
        zero_q  <= alu_zero;
`ifdef ALU_BEQ_EN
        cmp_q   <= alu_cmp;
`endif
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    alu_op      = 1'b0;
    rf_we       = 1'b0;
    rf_a3       = '0;
    rf_d3       = '0;
    done        = 1'b0;
    skipped     = 1'b0;
    illegal     = 1'b0;
    we_c        = 1'b0;
    we_z        = 1'b0;
`ifdef ALU_BEQ_EN
    br_taken    = 1'b0;
    br_off      = '0;
`endif
    unique case (state_q)
      StIdle: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = StRd;
      end
      StRd: state_d = exec ? StEx : StWb;
      StEx: begin
        alu_op  = is_nand;
        state_d = StWb;
      end
      StWb: begin
        done    = 1'b1;
        skipped = skip_q;
        illegal = ill_q;
        rf_we   = ~skip_q & ~is_beq;
        rf_a3   = is_adi ? rb : rc;
        rf_d3   = res_q;
        we_c    = rf_we & ~is_nand;
        we_z    = rf_we;
`ifdef ALU_BEQ_EN
        br_taken = is_beq & cmp_q;
        br_off   = is_beq ? imm6 : 6'd0;
`endif
        state_d = StIdle;
      end
    endcase
  end

  alu_flag_reg u_flags (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_c   (we_c),
    .we_z   (we_z),
    .c_new  (carry_q),
    .z_new  (zero_q),
    .flag_c (flag_c),
    .flag_z (flag_z)
  );

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural register file + ALU around the DUT,
// an instruction-level reference model and a per-cycle compare process.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid, instr_ready;
  logic [15:0] instr;
  logic [2:0]  rf_a1, rf_a2, rf_a3;
  logic [15:0] rf_d1, rf_d2, rf_d3, alu_in1, alu_in2, alu_out;
  logic        alu_op, alu_carry, alu_zero, alu_cmp;
  logic        rf_we, flag_c, flag_z, done, skipped, illegal;
`ifdef ALU_BEQ_EN
  logic        br_taken;
  logic [5:0]  br_off;
`endif

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_d1(rf_d1), .rf_d2(rf_d2),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_cmp(alu_cmp), .rf_we(rf_we),
    .rf_a3(rf_a3), .rf_d3(rf_d3), .flag_c(flag_c), .flag_z(flag_z), .done(done),
    .skipped(skipped), .illegal(illegal)
`ifdef ALU_BEQ_EN
    , .br_taken(br_taken), .br_off(br_off)
`endif
  );

  // Environment: register file (with a bench load port) and ALU.
  logic [15:0] tb_rf [8] = '{default: 16'h0000};
  logic        load_en = 1'b0;
  logic [2:0]  load_addr = 3'd0;
  logic [15:0] load_data = 16'h0;
  logic [16:0] alu_sum;

  always @(posedge clk) begin
    if (rf_we) tb_rf[rf_a3] <= rf_d3;
    else if (load_en) tb_rf[load_addr] <= load_data;
  end
  assign rf_d1 = tb_rf[rf_a1];
  assign rf_d2 = tb_rf[rf_a2];

  always_comb begin
    alu_sum   = {1'b0, alu_in1} + {1'b0, alu_in2};
    alu_out   = alu_op ? ~(alu_in1 & alu_in2) : alu_sum[15:0];
    alu_carry = alu_op ? 1'b0 : alu_sum[16];
    alu_zero  = (alu_out == 16'h0);
    alu_cmp   = (alu_in1 == alu_in2);
  end

  // Reference model state and current expectation.
  logic [15:0] model_rf [8] = '{default: 16'h0000};
  logic        model_c = 1'b0, model_z = 1'b0;
  int          cyc = 0, acc_cyc = 0, exp_done_cyc = 0;
  logic        pending = 1'b0;
  logic        exp_we, exp_skip, exp_ill, exp_c, exp_z, exp_beq, exp_br;
  logic [2:0]  exp_a3;
  logic [15:0] exp_d3;
  logic [5:0]  exp_off;
  logic [15:0] last_d3;
  logic        last_ill, last_skip, last_br;
  logic [5:0]  last_off;
  int          last_lat;
  int          n_checks = 0, n_fail = 0;
  logic        edone;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] r(input logic [3:0] op, input int ra, input int rb,
                                    input int rc, input logic [1:0] cz);
    return {op, ra[2:0], rb[2:0], rc[2:0], 1'b0, cz};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
      model_c = 1'b0;
      model_z = 1'b0;
      chk("rst_ready", instr_ready, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_we", rf_we, 1'b0);
      chk("rst_flags", {flag_c, flag_z}, 2'b00);
    end else begin
      if (load_en) model_rf[load_addr] = load_data;
      edone = pending && (cyc == exp_done_cyc);
      chk("ready", instr_ready, !pending || (cyc == acc_cyc));
      chk("done", done, edone);
      chk("rf_we", rf_we, edone && exp_we);
      chk("flag_c", flag_c, model_c);
      chk("flag_z", flag_z, model_z);
      if (edone) begin
        chk("skipped", skipped, exp_skip);
        chk("illegal", illegal, exp_ill);
        if (exp_we) begin
          chk("rf_a3", rf_a3, exp_a3);
          chk("rf_d3", rf_d3, exp_d3);
        end
`ifdef ALU_BEQ_EN
        if (exp_beq) begin
          chk("br_taken", br_taken, exp_br);
          chk("br_off", br_off, exp_off);
        end
        last_br  = br_taken;
        last_off = br_off;
`endif
        last_d3   = rf_d3;
        last_ill  = illegal;
        last_skip = skipped;
        last_lat  = cyc - acc_cyc;
        if (exp_we) model_rf[exp_a3] = exp_d3;
        model_c = exp_c;
        model_z = exp_z;
        pending = 1'b0;
      end else if (pending && cyc > exp_done_cyc) begin
        chk("done_timeout", done, 1'b1);
        pending = 1'b0;
      end
    end
  end

  // Computes the expected outcome from architectural state, then offers ins.
  task automatic start(input logic [15:0] ins);
    logic [3:0]  op;
    logic [1:0]  cz;
    logic [15:0] a, b, res;
    logic [16:0] sum;
    logic        rtype, legal, run, beq_on;
`ifdef ALU_BEQ_EN
    beq_on = 1'b1;
`else
    beq_on = 1'b0;
`endif
    op    = ins[15:12];
    cz    = ins[1:0];
    a     = model_rf[ins[11:9]];
    b     = (op == 4'h1) ? {{10{ins[5]}}, ins[5:0]} : model_rf[ins[8:6]];
    rtype = (op == 4'h0) || (op == 4'h2);
    legal = (op == 4'h1) || (rtype && cz != 2'b11) || (beq_on && op == 4'hc);
    run   = legal && !(rtype && ((cz == 2'b10 && !model_c) || (cz == 2'b01 && !model_z)));
    sum   = {1'b0, a} + {1'b0, b};
    res   = (op == 4'h2) ? ~(a & b) : sum[15:0];
    exp_ill  = !legal;
    exp_skip = !run;
    exp_beq  = run && (op == 4'hc);
    exp_we   = run && !exp_beq;
    exp_a3   = (op == 4'h1) ? ins[8:6] : ins[5:3];
    exp_d3   = res;
    exp_c    = (exp_we && op != 4'h2) ? sum[16] : model_c;
    exp_z    = exp_we ? (res == 16'h0) : model_z;
    exp_br   = (a == b);
    exp_off  = ins[5:0];
    acc_cyc      = cyc;
    exp_done_cyc = cyc + (run ? 3 : 2);
    pending      = 1'b1;
    instr_valid  = 1'b1;
    instr        = ins;
    @(posedge clk); #1;
    instr = 16'($urandom);  // must be ignored while busy
  endtask

  task automatic issue(input logic [15:0] ins);
    int n;
    start(ins);
    n = 0;
    while (pending && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (pending) chk("issue_timeout", 32'(n), 32'd0);
    instr_valid = 1'b0;
  endtask

  task automatic set_reg(input int a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a[2:0]; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    instr_valid = 1'b0;
    instr = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("lit_rst_ready", instr_ready, 1'b1);
    chk("lit_rst_alu_in1", alu_in1, 16'h0);
    chk("lit_rst_rf_a3", rf_a3, 3'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_reg(1, 16'hffff); set_reg(2, 16'h0001); set_reg(6, 16'hffff);

    issue(r(4'h0, 1, 2, 3, 2'b00));                         // ADD R3 = R1 + R2
    chk("lit_add_d3", last_d3, 16'h0000);
    chk("lit_add_lat", last_lat, 3);
    chk("lit_add_cz", {flag_c, flag_z}, 2'b11);
    issue(r(4'h0, 1, 1, 4, 2'b10));                         // ADC R4 = R1 + R1
    chk("lit_adc_d3", last_d3, 16'hfffe);
    chk("lit_adc_cz", {flag_c, flag_z}, 2'b10);
    issue(r(4'h0, 1, 2, 7, 2'b01));                         // ADZ, Z = 0 -> skip
    chk("lit_adz_lat", last_lat, 2);
    chk("lit_adz_skip", last_skip, 1'b1);
    chk("lit_adz_cz", {flag_c, flag_z}, 2'b10);
    issue(r(4'h2, 6, 6, 5, 2'b00));                         // NDU R5 = R6 nand R6
    chk("lit_ndu_d3", last_d3, 16'h0000);
    chk("lit_ndu_cz", {flag_c, flag_z}, 2'b11);
    set_reg(5, 16'h0005);
    issue({4'h1, 3'd5, 3'd2, 6'b111111});                   // ADI R2 = R5 + (-1)
    chk("lit_adi_d3", last_d3, 16'h0004);
    chk("lit_adi_cz", {flag_c, flag_z}, 2'b10);
    issue(r(4'h0, 1, 2, 3, 2'b11));                         // CZ = 11 -> illegal
    chk("lit_ill_lat", last_lat, 2);
    chk("lit_ill_flag", last_ill, 1'b1);
    issue(r(4'h7, 1, 2, 3, 2'b00));                         // unknown opcode
    chk("lit_ill7_flag", last_ill, 1'b1);
`ifndef ALU_BEQ_EN
    issue({4'hc, 3'd1, 3'd2, 6'd3});                        // BEQ absent -> illegal
    chk("lit_beq_ill", last_ill, 1'b1);
`endif
    issue(r(4'h2, 1, 2, 6, 2'b10));                         // NDC R6 = ffff nand 4
    chk("lit_ndc_d3", last_d3, 16'hfffb);
    chk("lit_ndc_cz", {flag_c, flag_z}, 2'b10);
    issue(r(4'h2, 1, 2, 6, 2'b01));                         // NDZ, Z = 0 -> skip
    issue(r(4'h0, 2, 2, 0, 2'b00));                         // ADD R0 = R2 + R2
    chk("lit_r0_d3", last_d3, 16'h0008);

    // Reset while an ADD (which would write R3 = R1 + R1) is in EX.
    start(r(4'h0, 1, 1, 3, 2'b00));
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("lit_mid_rst_done", done, 1'b0);
    chk("lit_mid_rst_we", rf_we, 1'b0);
    chk("lit_mid_rst_ready", instr_ready, 1'b1);
    chk("lit_mid_rst_c", flag_c, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(r(4'h0, 1, 2, 3, 2'b10));                         // ADC with C = 0 -> skip
    chk("lit_adc0_skip", last_skip, 1'b1);
    issue(r(4'h0, 3, 0, 7, 2'b00));                         // R7 = R3 + R0, R3 untouched
    chk("lit_r7_d3", last_d3, 16'h0008);

`ifdef ALU_BEQ_EN
    set_reg(1, 16'h1234); set_reg(2, 16'h1234);
    issue({4'hc, 3'd1, 3'd2, 6'd3});
    chk("lit_beq_taken", last_br, 1'b1);
    chk("lit_beq_off", last_off, 6'd3);
    chk("lit_beq_lat", last_lat, 3);
    set_reg(2, 16'h1235);
    issue({4'hc, 3'd1, 3'd2, 6'd3});
    chk("lit_beq_not_taken", last_br, 1'b0);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
